// File: rtl/elastic_skid_buffer.sv
// elastic_skid_buffer
// Fully-registered valid/ready elastic buffer of DEPTH entries: an output
// (head) register fed by a circular store of DEPTH-1 entries. Every output
// is a flop, so timing is cut in both directions. Also provides an
// occupancy count, an almost-full flag and a synchronous flush.
//
// Handshake semantics (both sides): a beat transfers on a rising clk edge
// where valid and ready are both high. Once valid is raised it must stay
// high, with data stable, until that edge. The buffer honours this on the
// forward side. The upstream side is trusted to do the same and is not
// checked.

module elastic_skid_buffer #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] bwd_data_i,
    input  logic                  bwd_valid_i,
    output logic                  bwd_ready_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o,
    output logic                  fwd_valid_o,
    input  logic                  fwd_ready_i,
    output logic [CNT_W-1:0]      count_o,
    output logic                  almost_full_o
);

    // Storage sits behind the head register, so it holds one entry fewer
    // than the total capacity.
    localparam int STO_DEPTH = DEPTH - 1;
    localparam int PTR_W     = (STO_DEPTH > 1) ? $clog2(STO_DEPTH) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(STO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] sto_mem [STO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      sto_cnt;

    logic                  push;
    logic                  pop;
    logic                  sto_empty;
    logic                  head_from_in;
    logic                  head_from_sto;
    logic                  sto_wr;
    logic [CNT_W-1:0]      count_next;
    logic [CNT_W-1:0]      sto_cnt_next;

    // Pointers wrap at the last storage slot. The storage size need not be
    // a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Handshakes and routing. Incoming data bypasses storage whenever the
    // head is, or is about to become, empty with nothing queued behind it.
    always_comb begin
        push          = bwd_valid_i & bwd_ready_o;
        pop           = fwd_valid_o & fwd_ready_i;
        sto_empty     = (sto_cnt == '0);
        head_from_in  = push & (~fwd_valid_o | (pop & sto_empty));
        head_from_sto = pop & ~sto_empty;
        sto_wr        = push & ~head_from_in;
    end

    // Next occupancy, both total and storage-only.
    always_comb begin
        count_next = count_o;
        if (push && !pop) begin
            count_next = count_o + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_o - CNT_W'(1);
        end

        sto_cnt_next = sto_cnt;
        if (sto_wr && !head_from_sto) begin
            sto_cnt_next = sto_cnt + CNT_W'(1);
        end else if (head_from_sto && !sto_wr) begin
            sto_cnt_next = sto_cnt - CNT_W'(1);
        end
    end

    // Storage array write. Contents need no reset because sto_cnt guards
    // every read.
    always_ff @(posedge clk) begin
        if (sto_wr && !flush_i) begin
            sto_mem[wr_ptr] <= bwd_data_i;
        end
    end

    // Head register: load from the input or from storage, or empty on a
    // pop with nothing behind it. It holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid_o <= 1'b0;
            fwd_data_o  <= '0;
        end else if (flush_i) begin
            fwd_valid_o <= 1'b0;
        end else if (head_from_in) begin
            fwd_valid_o <= 1'b1;
            fwd_data_o  <= bwd_data_i;
        end else if (head_from_sto) begin
            fwd_valid_o <= 1'b1;
            fwd_data_o  <= sto_mem[rd_ptr];
        end else if (pop) begin
            fwd_valid_o <= 1'b0;
        end
    end

    // Storage pointers and fill level. Flush takes priority over any
    // movement in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            sto_cnt <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            sto_cnt <= '0;
        end else begin
            if (sto_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (head_from_sto) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            sto_cnt <= sto_cnt_next;
        end
    end

    // Registered status. Ready comes from the next occupancy, so it drops
    // the cycle after the buffer fills and rises the cycle after a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_o       <= '0;
            bwd_ready_o   <= 1'b1;
            almost_full_o <= 1'b0;
        end else if (flush_i) begin
            count_o       <= '0;
            bwd_ready_o   <= 1'b1;
            almost_full_o <= 1'b0;
        end else begin
            count_o       <= count_next;
            bwd_ready_o   <= (count_next < DEPTH_C);
            almost_full_o <= (count_next >= THRESH_C);
        end
    end

endmodule

// File: tb/tb_elastic_skid_buffer.sv
// tb_elastic_skid_buffer
// Two instances run side by side: DEPTH=4 (u0) and DEPTH=3 (u1). A queue
// model tracks each instance's contents. The head is the queue front,
// occupancy is the queue size, and ready/almost-full follow from that size.
// A compare process checks every output against the model on each falling
// edge. Directed phases add literal expectations.

module tb_elastic_skid_buffer;

    logic       clk;
    logic       rst_n;
    logic       bv [2];
    logic [7:0] bd [2];
    logic       fr [2];
    logic       fl [2];

    logic       fv0, fv1, br0, br1, af0, af1;
    logic [7:0] fd0, fd1;
    logic [2:0] cnt4;
    logic [1:0] cnt3;

    logic       fv [2];
    logic       br [2];
    logic       af [2];
    logic [7:0] fd [2];
    logic [2:0] cnt [2];

    // model state
    logic [7:0] mq [2][$];
    int         net [2];
    int         dep [2];
    int         thr [2];
    bit         push_d [2];
    bit         pop_d [2];
    bit         chk_en;

    int         n_checks;
    int         n_errors;

    elastic_skid_buffer #(.DATA_WIDTH(8), .DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .flush_i(fl[0]),
        .bwd_data_i(bd[0]), .bwd_valid_i(bv[0]), .bwd_ready_o(br0),
        .fwd_data_o(fd0), .fwd_valid_o(fv0), .fwd_ready_i(fr[0]),
        .count_o(cnt4), .almost_full_o(af0)
    );

    elastic_skid_buffer #(.DATA_WIDTH(8), .DEPTH(3)) u1 (
        .clk(clk), .rst_n(rst_n), .flush_i(fl[1]),
        .bwd_data_i(bd[1]), .bwd_valid_i(bv[1]), .bwd_ready_o(br1),
        .fwd_data_o(fd1), .fwd_valid_o(fv1), .fwd_ready_i(fr[1]),
        .count_o(cnt3), .almost_full_o(af1)
    );

    always_comb begin
        fv[0]  = fv0;  fv[1]  = fv1;
        br[0]  = br0;  br[1]  = br1;
        af[0]  = af0;  af[1]  = af1;
        fd[0]  = fd0;  fd[1]  = fd1;
        cnt[0] = cnt4; cnt[1] = {1'b0, cnt3};
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: decide handshakes from the model, advance the model at the
    // rising edge, return at the following falling edge.
    task automatic cycle();
        for (int i = 0; i < 2; i++) begin
            push_d[i] = rst_n && bv[i] && (mq[i].size() < dep[i]);
            pop_d[i]  = rst_n && fr[i] && (mq[i].size() > 0);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || fl[i]) begin
                mq[i].delete();
                net[i] = 0;
            end else begin
                if (pop_d[i]) void'(mq[i].pop_front());
                if (push_d[i]) mq[i].push_back(bd[i]);
                net[i] += int'(push_d[i]) - int'(pop_d[i]);
            end
        end
        @(negedge clk);
    endtask

    // random upstream/downstream behaviour; valid is held until accepted
    task automatic rnd_drive(input int i);
        if (!bv[i] && $urandom_range(0, 3) != 0) begin
            bv[i] = 1'b1;
            bd[i] = 8'($urandom);
        end
        fr[i] = (i == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) != 0);
        fl[i] = ($urandom_range(0, 99) == 0);
    endtask

    // scoreboard compare on every falling edge
    always @(negedge clk) begin
        int sz;
        if (chk_en && rst_n) begin
            for (int i = 0; i < 2; i++) begin
                sz = mq[i].size();
                chk($sformatf("u%0d fwd_valid", i), 32'(fv[i]), 32'(sz != 0));
                if (sz != 0) chk($sformatf("u%0d fwd_data", i), 32'(fd[i]), 32'(mq[i][0]));
                chk($sformatf("u%0d count", i), 32'(cnt[i]), 32'(sz));
                chk($sformatf("u%0d count_vs_net", i), 32'(cnt[i]), 32'(net[i]));
                chk($sformatf("u%0d bwd_ready", i), 32'(br[i]), 32'(sz < dep[i]));
                chk($sformatf("u%0d almost_full", i), 32'(af[i]), 32'(sz >= thr[i]));
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, " u0 fwd_valid"}, 32'(fv0), 0);
        chk({tag, " u0 fwd_data"}, 32'(fd0), 0);
        chk({tag, " u0 bwd_ready"}, 32'(br0), 1);
        chk({tag, " u0 count"}, 32'(cnt4), 0);
        chk({tag, " u0 almost_full"}, 32'(af0), 0);
        chk({tag, " u1 fwd_valid"}, 32'(fv1), 0);
        chk({tag, " u1 bwd_ready"}, 32'(br1), 1);
        chk({tag, " u1 count"}, 32'(cnt3), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 1'b0;
        dep[0] = 4; thr[0] = 3;
        dep[1] = 3; thr[1] = 2;
        for (int i = 0; i < 2; i++) begin
            bv[i] = 1'b0; bd[i] = '0; fr[i] = 1'b0; fl[i] = 1'b0; net[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // single beat
        bv[0] = 1'b1; bd[0] = 8'hA5; fr[0] = 1'b1;
        cycle();
        bv[0] = 1'b0;
        chk("single valid", 32'(fv0), 1);
        chk("single data", 32'(fd0), 32'hA5);
        chk("single count", 32'(cnt4), 1);
        cycle();
        chk("single drained valid", 32'(fv0), 0);
        chk("single drained count", 32'(cnt4), 0);

        // fill to full
        fr[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bv[0] = 1'b1; bd[0] = 8'(k);
            cycle();
            chk("fill count", 32'(cnt4), 32'(k));
            chk("fill almost_full", 32'(af0), 32'(k >= 3));
        end
        chk("full ready", 32'(br0), 0);
        bv[0] = 1'b1; bd[0] = 8'h05;
        repeat (2) cycle();
        chk("full held count", 32'(cnt4), 4);
        chk("full held head", 32'(fd0), 32'h01);

        // drain in order; 0x05 enters once space appears
        fr[0] = 1'b1;
        cycle();
        chk("drain data 02", 32'(fd0), 32'h02);
        chk("drain ready back", 32'(br0), 1);
        chk("drain count 3", 32'(cnt4), 3);
        cycle();
        if (push_d[0]) bv[0] = 1'b0;
        chk("drain 05 accepted", 32'(push_d[0]), 1);
        chk("drain data 03", 32'(fd0), 32'h03);
        cycle();
        chk("drain data 04", 32'(fd0), 32'h04);
        cycle();
        chk("drain data 05", 32'(fd0), 32'h05);
        cycle();
        chk("drain empty", 32'(fv0), 0);

        // streaming
        for (int k = 0; k < 20; k++) begin
            bv[0] = 1'b1; bd[0] = 8'(k);
            cycle();
            chk("stream accepted", 32'(push_d[0]), 1);
            chk("stream data", 32'(fd0), 32'(k));
            chk("stream count", 32'(cnt4), 1);
        end
        bv[0] = 1'b0;
        cycle();
        chk("stream end valid", 32'(fv0), 0);

        // flush with simultaneous push
        fr[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bv[0] = 1'b1; bd[0] = 8'(8'h10 + k);
            cycle();
        end
        chk("preflush count", 32'(cnt4), 3);
        bv[0] = 1'b1; bd[0] = 8'h77; fl[0] = 1'b1;
        cycle();
        fl[0] = 1'b0; bv[0] = 1'b0;
        chk("flush count", 32'(cnt4), 0);
        chk("flush valid", 32'(fv0), 0);
        chk("flush ready", 32'(br0), 1);
        chk("flush almost_full", 32'(af0), 0);
        fr[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("post flush no 0x77", 32'(fv0), 0);
        end

        // random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            rnd_drive(0);
            rnd_drive(1);
            cycle();
            for (int i = 0; i < 2; i++) if (push_d[i]) bv[i] = 1'b0;
        end

        // asynchronous reset mid-stream, checked between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async reset");
        for (int i = 0; i < 2; i++) begin
            mq[i].delete(); net[i] = 0; bv[i] = 1'b0; fl[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            rnd_drive(0);
            rnd_drive(1);
            cycle();
            for (int i = 0; i < 2; i++) if (push_d[i]) bv[i] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            bv[i] = 1'b0; fr[i] = 1'b1; fl[i] = 1'b0;
        end
        repeat (8) cycle();
        chk("final u0 empty", 32'(cnt4), 0);
        chk("final u1 empty", 32'(cnt3), 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
